// File: rtl/btb_pkg.sv
// Shared definitions for the BTB jump write-back path: widths, entry layout,
// controller state encoding and jump-target formation.
package btb_pkg;

  localparam int unsigned BTB_IDX_W = 4;
  localparam int unsigned BTB_TAG_W = 26;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned JIDX_W    = 26;

  // One queued BTB write: set index, tag and the target to store.
  typedef struct packed {
    logic [BTB_IDX_W-1:0] idx;
    logic [BTB_TAG_W-1:0] tag;
    logic [PC_W-1:0]      target;
  } btb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } upd_state_t;

  // J/JAL target: upper nibble of the delay-slot PC, instr_index, word aligned.
  function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0]   pc,
                                                  input logic [JIDX_W-1:0] instr_index);
    logic [PC_W-1:0] pc4;
    pc4 = pc + 32'd4;
    return {pc4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO holding pending BTB write-backs. Besides push/pop it offers
// a flush, an in-place overwrite of the tail entry, and a look-ahead of the
// entry that will sit at the head after the coming clock edge.
module btb_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 62
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     ovr,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic [W-1:0]             head_nxt,
  output logic [W-1:0]             tail
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] rd_nxt;
  logic          wr_en;

  assign full    = (count == CW'(DEPTH));
  assign wr_addr = ovr ? (wr_ptr - PW'(1)) : wr_ptr;
  assign wr_en   = (push || ovr) && !flush;
  assign rd_nxt  = rd_ptr + PW'(pop);
  assign tail    = mem[wr_ptr - PW'(1)];

  // Post-edge occupancy; flush empties the queue regardless of push/pop.
  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CW'(push) - CW'(pop);
  end

  // Head after this edge, forwarding a same-edge write into that slot so the
  // consumer can register it without waiting a cycle.
  always_comb begin
    head_nxt = mem[rd_nxt];
    if (wr_en && (wr_addr == rd_nxt)) head_nxt = din;
  end

  // Entry storage; no reset needed since pointers qualify validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/btb_jump_update_ctrl.sv
// BTB write-back scheduler for resolved J/JAL instructions. Forms the jump
// target, queues {idx, tag, target} and requests the shared BTB write port,
// yielding to fetch reads via btb_wr_gnt.
// Optional macro BTB_UPD_COALESCE_EN: an update matching the not-yet-issued
// tail entry overwrites that entry instead of taking a new slot.
module btb_jump_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [31:0]              upd_pc,
  input  logic [25:0]              upd_instr_index,
  input  logic                     flush,
  output logic                     btb_wr_req,
  input  logic                     btb_wr_gnt,
  output logic [IDX_W-1:0]         btb_wr_idx,
  output logic [TAG_W-1:0]         btb_wr_tag,
  output logic [31:0]              btb_wr_target,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = IDX_W + TAG_W + PC_W;

  upd_state_t       state;
  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_target;
  logic [EW-1:0]    din;
  logic [EW-1:0]    head_nxt;
  logic [EW-1:0]    tail;
  logic [CW-1:0]    count_nxt;
  logic             full;
  logic             accept;
  logic             coal;
  logic             push;
  logic             pop;

  assign upd_ready = (count != CW'(DEPTH));
  assign in_idx    = upd_pc[IDX_W+1:2];
  assign in_tag    = upd_pc[31:IDX_W+2];
  assign in_target = jump_target(upd_pc, upd_instr_index);
  assign din       = {in_idx, in_tag, in_target};
  assign accept    = upd_valid && upd_ready && !flush;
  assign pop       = btb_wr_req && btb_wr_gnt;

`ifdef BTB_UPD_COALESCE_EN
  // A head granted this edge has issued, so it is no longer a merge target.
  assign coal = accept && (count != '0) && !(pop && (count == CW'(1)))
             && (tail[EW-1:PC_W] == {in_idx, in_tag});
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign coal        = 1'b0;
`endif

  assign push = accept && !coal;

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .ovr       (coal),
    .din       (din),
    .pop       (pop),
    .full      (full),
    .count     (count),
    .count_nxt (count_nxt),
    .head_nxt  (head_nxt),
    .tail      (tail)
  );

  // Write-port FSM with registered request and payload. Reloading from the
  // FIFO look-ahead every REQ cycle covers hold, retire-and-advance and
  // in-place payload updates with one path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      btb_wr_req    <= 1'b0;
      btb_wr_idx    <= '0;
      btb_wr_tag    <= '0;
      btb_wr_target <= '0;
    end else if (flush) begin
      state         <= IDLE;
      btb_wr_req    <= 1'b0;
      btb_wr_idx    <= '0;
      btb_wr_tag    <= '0;
      btb_wr_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= REQ;
            btb_wr_req <= 1'b1;
            {btb_wr_idx, btb_wr_tag, btb_wr_target} <= head_nxt;
          end
        end
        REQ: begin
          if (count_nxt != '0) begin
            btb_wr_req <= 1'b1;
            {btb_wr_idx, btb_wr_tag, btb_wr_target} <= head_nxt;
          end else begin
            state      <= IDLE;
            btb_wr_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_jump_update_ctrl.sv
// Directed self-checking bench for btb_jump_update_ctrl (default parameters).
module tb_btb_jump_update_ctrl;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [25:0] upd_instr_index;
  logic        flush;
  logic        btb_wr_req;
  logic        btb_wr_gnt;
  logic [3:0]  btb_wr_idx;
  logic [25:0] btb_wr_tag;
  logic [31:0] btb_wr_target;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  btb_jump_update_ctrl #(
    .DEPTH (4),
    .IDX_W (4),
    .TAG_W (26)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_pc          (upd_pc),
    .upd_instr_index (upd_instr_index),
    .flush           (flush),
    .btb_wr_req      (btb_wr_req),
    .btb_wr_gnt      (btb_wr_gnt),
    .btb_wr_idx      (btb_wr_idx),
    .btb_wr_tag      (btb_wr_tag),
    .btb_wr_target   (btb_wr_target),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [25:0] ix);
    upd_valid       = v;
    upd_pc          = pc;
    upd_instr_index = ix;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    btb_wr_gnt = 1'b0;
    drive(1'b0, 32'h0, 26'h0);
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req", 32'(btb_wr_req), 32'd0);
    chk("rst_target", btb_wr_target, 32'h0);
    chk("rst_idx", 32'(btb_wr_idx), 32'h0);
    chk("rst_tag", 32'(btb_wr_tag), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(upd_ready), 32'd1);

    // Single update, granted immediately
    btb_wr_gnt = 1'b1;
    drive(1'b1, 32'h0040_0000, 26'h010_0010);
    step();
    chk("single_cnt_after_push", 32'(count), 32'd1);
    chk("single_req_not_yet", 32'(btb_wr_req), 32'd0);
    drive(1'b0, 32'h0, 26'h0);
    step();
    chk("single_req", 32'(btb_wr_req), 32'd1);
    chk("single_target", btb_wr_target, 32'h0040_0040);
    chk("single_idx", 32'(btb_wr_idx), 32'h0);
    chk("single_tag", 32'(btb_wr_tag), 32'h0001_0000);
    step();
    chk("single_retired_req", 32'(btb_wr_req), 32'd0);
    chk("single_retired_cnt", 32'(count), 32'd0);

    // PC+4 wraps to zero
    btb_wr_gnt = 1'b0;
    drive(1'b1, 32'hFFFF_FFFC, 26'h3FF_FFFF);
    step();
    drive(1'b0, 32'h0, 26'h0);
    step();
    chk("wrap_req", 32'(btb_wr_req), 32'd1);
    chk("wrap_target", btb_wr_target, 32'h0FFF_FFFC);
    chk("wrap_idx", 32'(btb_wr_idx), 32'hF);
    chk("wrap_tag", 32'(btb_wr_tag), 32'h03FF_FFFF);
    step();
    chk("wrap_hold_req", 32'(btb_wr_req), 32'd1);
    chk("wrap_hold_target", btb_wr_target, 32'h0FFF_FFFC);
    btb_wr_gnt = 1'b1;
    step();
    chk("wrap_retired_req", 32'(btb_wr_req), 32'd0);
    chk("wrap_retired_cnt", 32'(count), 32'd0);

    // Fill to full with grant withheld
    btb_wr_gnt = 1'b0;
    drive(1'b1, 32'h0000_1000, 26'h11); step();
    drive(1'b1, 32'h0000_2004, 26'h22); step();
    drive(1'b1, 32'h0000_3008, 26'h33); step();
    drive(1'b1, 32'h0000_400C, 26'h44); step();
    chk("fill_cnt", 32'(count), 32'd4);
    chk("fill_ready", 32'(upd_ready), 32'd0);
    drive(1'b1, 32'h0000_5000, 26'h55); step();
    chk("fill_5th_ignored", 32'(count), 32'd4);
    chk("fill_head_target", btb_wr_target, 32'h0000_0044);
    chk("fill_head_tag", 32'(btb_wr_tag), 32'h40);
    drive(1'b0, 32'h0, 26'h0);
    btb_wr_gnt = 1'b1;
    step();
    chk("drain1_target", btb_wr_target, 32'h0000_0088);
    chk("drain1_idx", 32'(btb_wr_idx), 32'h1);
    chk("drain1_cnt", 32'(count), 32'd3);
    chk("drain1_ready", 32'(upd_ready), 32'd1);
    step();
    chk("drain2_target", btb_wr_target, 32'h0000_00CC);
    chk("drain2_tag", 32'(btb_wr_tag), 32'hC0);
    step();
    chk("drain3_target", btb_wr_target, 32'h0000_0110);
    chk("drain3_idx", 32'(btb_wr_idx), 32'h3);
    chk("drain3_cnt", 32'(count), 32'd1);
    step();
    chk("drain4_req", 32'(btb_wr_req), 32'd0);
    chk("drain4_cnt", 32'(count), 32'd0);

    // Simultaneous push and retire at count=2
    btb_wr_gnt = 1'b0;
    drive(1'b1, 32'h0000_0100, 26'hA); step();
    drive(1'b1, 32'h0000_0200, 26'hB); step();
    chk("simul_pre_cnt", 32'(count), 32'd2);
    chk("simul_pre_target", btb_wr_target, 32'h0000_0028);
    drive(1'b1, 32'h0000_0300, 26'hC);
    btb_wr_gnt = 1'b1;
    step();
    chk("simul_cnt", 32'(count), 32'd2);
    chk("simul_target", btb_wr_target, 32'h0000_002C);
    drive(1'b0, 32'h0, 26'h0);
    step();
    chk("simul_next_target", btb_wr_target, 32'h0000_0030);
    step();
    chk("simul_done_req", 32'(btb_wr_req), 32'd0);

    // Push and retire with a single entry: new entry becomes head directly
    btb_wr_gnt = 1'b0;
    drive(1'b1, 32'h0000_0400, 26'hD); step();
    drive(1'b0, 32'h0, 26'h0); step();
    chk("one_target", btb_wr_target, 32'h0000_0034);
    drive(1'b1, 32'h0000_0500, 26'hE);
    btb_wr_gnt = 1'b1;
    step();
    chk("one_fwd_cnt", 32'(count), 32'd1);
    chk("one_fwd_req", 32'(btb_wr_req), 32'd1);
    chk("one_fwd_target", btb_wr_target, 32'h0000_0038);
    chk("one_fwd_tag", 32'(btb_wr_tag), 32'h14);
    drive(1'b0, 32'h0, 26'h0);
    step();
    chk("one_done_cnt", 32'(count), 32'd0);

    // Flush with three queued plus a same-cycle push
    btb_wr_gnt = 1'b0;
    drive(1'b1, 32'h0000_0600, 26'h1); step();
    drive(1'b1, 32'h0000_0700, 26'h2); step();
    drive(1'b1, 32'h0000_0800, 26'h3); step();
    chk("flush_pre_cnt", 32'(count), 32'd3);
    drive(1'b1, 32'h0000_0900, 26'h4);
    flush = 1'b1;
    step();
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_req", 32'(btb_wr_req), 32'd0);
    chk("flush_ready", 32'(upd_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 26'h0);
    step();
    chk("flush_post_cnt", 32'(count), 32'd0);
    chk("flush_post_req", 32'(btb_wr_req), 32'd0);

    // Repeated update to the same BTB slot
    drive(1'b1, 32'h1000_0008, 26'h1); step();
    drive(1'b1, 32'h1000_0008, 26'h2); step();
    drive(1'b0, 32'h0, 26'h0);
`ifdef BTB_UPD_COALESCE_EN
    chk("coal_cnt", 32'(count), 32'd1);
    chk("coal_target", btb_wr_target, 32'h1000_0008);
`else
    chk("nocoal_cnt", 32'(count), 32'd2);
    chk("nocoal_target", btb_wr_target, 32'h1000_0004);
`endif
    chk("dup_idx", 32'(btb_wr_idx), 32'h2);
    chk("dup_tag", 32'(btb_wr_tag), 32'h0040_0000);
    btb_wr_gnt = 1'b1;
    step();
`ifdef BTB_UPD_COALESCE_EN
    chk("coal_drain_req", 32'(btb_wr_req), 32'd0);
`else
    chk("nocoal_drain_target", btb_wr_target, 32'h1000_0008);
    step();
    chk("nocoal_drain_req", 32'(btb_wr_req), 32'd0);
`endif
    chk("dup_drain_cnt", 32'(count), 32'd0);

    // Asynchronous reset while a request is outstanding
    btb_wr_gnt = 1'b0;
    drive(1'b1, 32'h0000_0A00, 26'h9); step();
    drive(1'b0, 32'h0, 26'h0); step();
    chk("arst_pre_req", 32'(btb_wr_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(btb_wr_req), 32'd0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_target", btb_wr_target, 32'h0);
    rst_n = 1'b1;
    step();
    chk("arst_post_req", 32'(btb_wr_req), 32'd0);
    chk("arst_post_ready", 32'(upd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
